// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// RV32I memory stage. Takes the ex_mem pipeline register, performs a load or
// store on a req/ack data bus and produces the mem_wb register for writeback.
// Non-memory instructions pass straight through in one cycle. While a bus
// access is outstanding, or its result cannot be handed to writeback, the
// stage holds upstream by keeping rdy low.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   en           stage enable; low kills the slot (no new request, valid=0)
//   next_rdy     writeback stage can accept mem_wb
//   ex_mem       input pipeline register (held stable while rdy=0)
//   dmem_*       data bus: req/we/addr/be/wdata out, ack/rdata/err in
//   mem_wb       output pipeline register
//   rdy          stage can accept the next ex_mem
// ---------------------------------------------------------------------------

package core;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } de_inst_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        de_inst_t    de_inst;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [31:0] ex_result;
        logic        valid;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        de_inst_t    de_inst;
        logic [31:0] wb_value;
        logic        fault;
        logic        valid;
    } mem_wb_t;

    localparam mem_wb_t mem_wb_rst = '0;

endpackage

module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          next_rdy,
    input  core::ex_mem_t ex_mem,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [31:0]   dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_err,
    output core::mem_wb_t mem_wb,
    output logic          rdy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             live_q;       // en has stayed high since the access was issued
    logic [31:0]      hold_rdata_q;
    logic             hold_err_q;
    logic             hold_to_q;

    // ---------------- decode ----------------
    logic [31:0] addr;
    logic [1:0]  size;
    logic        is_load;
    logic        is_store;
    logic        mem_op;
    logic        misaligned;

    assign addr       = ex_mem.rs1_value + ex_mem.de_inst.imm;
    assign size       = ex_mem.de_inst.funct3[1:0];
    assign is_load    = ex_mem.de_inst.opcode == core::OPC_LOAD;
    assign is_store   = ex_mem.de_inst.opcode == core::OPC_STORE;
    assign mem_op     = ex_mem.valid && (is_load || is_store);
    // funct3[1:0]=2'b11 is not a legal RV32I size; it is treated as a word.
    assign misaligned = (size == 2'b01 && addr[0]) ||
                        (size[1] && addr[1:0] != 2'b00);

    // ---------------- bus outputs ----------------
    assign dmem_we   = is_store;
    assign dmem_addr = {addr[31:2], 2'b00};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        dmem_be    = 4'hF;
        dmem_wdata = ex_mem.rs2_value;
        case (size)
            2'b00: begin
                dmem_be    = 4'b0001 << addr[1:0];
                dmem_wdata = {4{ex_mem.rs2_value[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << addr[1:0];
                dmem_wdata = {2{ex_mem.rs2_value[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        dmem_req = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE:  dmem_req = en && mem_op && !misaligned;
                S_WAIT:  dmem_req = 1'b1;
                default: dmem_req = 1'b0;
            endcase
        end
    end

    // ---------------- completion ----------------
    // An ack at the limit count wins over the timeout.
    logic timeout;
    logic access_end;
    logic complete;

    assign timeout    = (state_q == S_WAIT) && !dmem_ack && (cnt_q == CNT_LIMIT);
    assign access_end = (state_q == S_WAIT) && (dmem_ack || timeout);

    always_comb begin
        complete = 1'b0;
        case (state_q)
            S_IDLE:  complete = en && mem_op && next_rdy && (misaligned || (dmem_req && dmem_ack));
            S_WAIT:  complete = next_rdy && access_end;
            S_HOLD:  complete = next_rdy;
            default: complete = 1'b0;
        endcase
    end

    assign rdy = !rst && en && next_rdy && (!mem_op || complete);

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  ofs,
                                                 input logic [2:0]  f3);
        logic [31:0] shifted;
        shifted = word >> {ofs, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_extract = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_extract = {24'h0, shifted[7:0]};
            3'b101:  load_extract = {16'h0, shifted[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    // Result of the access completing now: live bus values, or the hold buffer.
    logic [31:0]   rdata_sel;
    logic          err_sel;
    logic          to_sel;
    logic          fault_c;
    core::mem_wb_t wb_next;

    always_comb begin
        rdata_sel = (state_q == S_HOLD) ? hold_rdata_q : dmem_rdata;
        err_sel   = (state_q == S_HOLD) ? hold_err_q   : (dmem_req && dmem_ack && dmem_err);
        to_sel    = (state_q == S_HOLD) ? hold_to_q    : timeout;
        fault_c   = misaligned || err_sel || to_sel;

        wb_next          = core::mem_wb_rst;
        wb_next.pc       = ex_mem.pc;
        wb_next.inst     = ex_mem.inst;
        wb_next.de_inst  = ex_mem.de_inst;
        if (mem_op || state_q != S_IDLE) begin
            wb_next.wb_value = (fault_c || is_store) ? 32'h0
                             : load_extract(rdata_sel, addr[1:0], ex_mem.de_inst.funct3);
            wb_next.fault    = fault_c;
            wb_next.valid    = en && (state_q == S_IDLE || live_q);
        end else begin
            wb_next.wb_value = ex_mem.ex_result;
            wb_next.fault    = 1'b0;
            wb_next.valid    = en && ex_mem.valid;
        end
    end

    logic pass_through;
    logic bubble;

    assign pass_through = (state_q == S_IDLE) && !mem_op && next_rdy;
    assign bubble       = next_rdy && (state_q != S_HOLD) && !complete && !pass_through;

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            mem_wb  <= core::mem_wb_rst;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dmem_req) begin
                        live_q <= 1'b1;
                        if (!dmem_ack) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(1);
                        end else if (!next_rdy) begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!en) live_q <= 1'b0;
                    if (access_end) begin
                        cnt_q   <= '0;
                        state_q <= next_rdy ? S_IDLE : S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!en) live_q <= 1'b0;
                    if (next_rdy) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (complete || pass_through) begin
                mem_wb <= wb_next;
            end else if (bubble) begin
                mem_wb.valid <= 1'b0;
            end
        end
    end

    // Hold buffer: captures the bus result when writeback is not ready.
    // NOTE: pure data registers without reset; they are only read in HOLD, which always follows a capture.
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE && dmem_req && dmem_ack && !next_rdy) ||
            (access_end && !next_rdy)) begin
            hold_rdata_q <= dmem_rdata;
            hold_err_q   <= dmem_ack && dmem_err;
            hold_to_q    <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed testbench for mem_stage. Inputs change 1 time unit after the
// rising edge; combinational outputs are sampled in the same window and
// registered outputs 1 unit after the edge that loads them.
// ---------------------------------------------------------------------------

module tb_mem_stage;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          next_rdy;
    core::ex_mem_t ex_mem;
    logic          dmem_req;
    logic          dmem_we;
    logic [31:0]   dmem_addr;
    logic [3:0]    dmem_be;
    logic [31:0]   dmem_wdata;
    logic          dmem_ack;
    logic [31:0]   dmem_rdata;
    logic          dmem_err;
    core::mem_wb_t mem_wb;
    logic          rdy;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .next_rdy   (next_rdy),
        .ex_mem     (ex_mem),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .dmem_err   (dmem_err),
        .mem_wb     (mem_wb),
        .rdy        (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [6:0]  opc,
                          input logic [2:0]  f3,
                          input logic [31:0] rs1,
                          input logic [31:0] imm,
                          input logic [31:0] rs2,
                          input logic [31:0] res,
                          input logic [31:0] pc);
        ex_mem                = '0;
        ex_mem.pc             = pc;
        ex_mem.inst           = pc ^ 32'h0000_0013;
        ex_mem.de_inst.opcode = opc;
        ex_mem.de_inst.funct3 = f3;
        ex_mem.de_inst.imm    = imm;
        ex_mem.rs1_value      = rs1;
        ex_mem.rs2_value      = rs2;
        ex_mem.ex_result      = res;
        ex_mem.valid          = 1'b1;
    endtask

    task automatic bus(input logic ack, input logic [31:0] rdata, input logic err);
        dmem_ack   = ack;
        dmem_rdata = rdata;
        dmem_err   = err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        rst      = 1'b1;
        en       = 1'b1;
        next_rdy = 1'b1;
        bus(1'b0, 32'h0, 1'b0);
        set_op(OPC_LOAD, 3'b010, 32'h100, 32'h0, 32'h0, 32'h0, 32'h10);

        // ---- reset ----
        step();
        check("rst_req", dmem_req, 0);
        check("rst_rdy", rdy, 0);
        step();
        check("rst_wb_valid", mem_wb.valid, 0);
        check("rst_wb_pc", mem_wb.pc, 0);
        check("rst_wb_value", mem_wb.wb_value, 0);
        rst = 1'b0;

        // ---- 1: lw, zero-wait ack ----
        set_op(OPC_LOAD, 3'b010, 32'h100, 32'h4, 32'h0, 32'h0, 32'h20);
        bus(1'b1, 32'hDEADBEEF, 1'b0);
        #1;
        check("lw_req", dmem_req, 1);
        check("lw_addr", dmem_addr, 32'h104);
        check("lw_be", dmem_be, 4'hF);
        check("lw_we", dmem_we, 0);
        check("lw_rdy", rdy, 1);
        step();
        check("lw_value", mem_wb.wb_value, 32'hDEADBEEF);
        check("lw_valid", mem_wb.valid, 1);
        check("lw_fault", mem_wb.fault, 0);
        check("lw_pc", mem_wb.pc, 32'h20);

        // ---- 2: byte / half extraction ----
        set_op(OPC_LOAD, 3'b000, 32'h100, 32'h3, 32'h0, 32'h0, 32'h24);
        bus(1'b1, 32'h80FFFFFF, 1'b0);
        #1;
        check("lb_be", dmem_be, 4'b1000);
        check("lb_addr", dmem_addr, 32'h100);
        step();
        check("lb_value", mem_wb.wb_value, 32'hFFFFFF80);
        set_op(OPC_LOAD, 3'b100, 32'h100, 32'h3, 32'h0, 32'h0, 32'h28);
        step();
        check("lbu_value", mem_wb.wb_value, 32'h00000080);
        set_op(OPC_LOAD, 3'b001, 32'h100, 32'h2, 32'h0, 32'h0, 32'h2C);
        bus(1'b1, 32'h80FF1234, 1'b0);
        step();
        check("lh_value", mem_wb.wb_value, 32'hFFFF80FF);
        set_op(OPC_LOAD, 3'b101, 32'h100, 32'h0, 32'h0, 32'h0, 32'h30);
        step();
        check("lhu_value", mem_wb.wb_value, 32'h00001234);

        // ---- 3: sh with a 3-cycle ack delay ----
        set_op(OPC_STORE, 3'b001, 32'h200, 32'h2, 32'h1234ABCD, 32'h0, 32'h34);
        bus(1'b0, 32'h0, 1'b0);
        #1;
        check("sh_be", dmem_be, 4'b1100);
        check("sh_wdata", dmem_wdata, 32'hABCDABCD);
        check("sh_we", dmem_we, 1);
        check("sh_addr", dmem_addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            check("sh_wait_req", dmem_req, 1);
            check("sh_wait_rdy", rdy, 0);
            step();
            check("sh_bubble", mem_wb.valid, 0);
        end
        bus(1'b1, 32'h0, 1'b0);
        #1;
        check("sh_ack_rdy", rdy, 1);
        step();
        check("sh_valid", mem_wb.valid, 1);
        check("sh_fault", mem_wb.fault, 0);
        check("sh_pc", mem_wb.pc, 32'h34);

        // ---- 4: ack while writeback stalled -> HOLD ----
        set_op(OPC_LOAD, 3'b010, 32'h300, 32'h0, 32'h0, 32'h0, 32'h38);
        bus(1'b1, 32'hCAFEF00D, 1'b0);
        next_rdy = 1'b0;
        #1;
        check("hold_req", dmem_req, 1);
        check("hold_rdy", rdy, 0);
        step();
        bus(1'b0, 32'h0, 1'b0);
        #1;
        check("hold_no_req1", dmem_req, 0);
        check("hold_wb_kept", mem_wb.pc, 32'h34);
        step();
        check("hold_no_req2", dmem_req, 0);
        next_rdy = 1'b1;
        #1;
        check("hold_release_rdy", rdy, 1);
        step();
        check("hold_value", mem_wb.wb_value, 32'hCAFEF00D);
        check("hold_valid", mem_wb.valid, 1);
        check("hold_pc", mem_wb.pc, 32'h38);

        // ---- bus error ----
        set_op(OPC_LOAD, 3'b010, 32'h340, 32'h0, 32'h0, 32'h0, 32'h3C);
        bus(1'b1, 32'h12345678, 1'b1);
        step();
        check("err_fault", mem_wb.fault, 1);
        check("err_valid", mem_wb.valid, 1);
        bus(1'b0, 32'h0, 1'b0);

        // ---- 5a: misaligned lw ----
        set_op(OPC_LOAD, 3'b010, 32'h100, 32'h1, 32'h0, 32'h0, 32'h40);
        #1;
        check("mis_req", dmem_req, 0);
        check("mis_rdy", rdy, 1);
        step();
        check("mis_fault", mem_wb.fault, 1);
        check("mis_value", mem_wb.wb_value, 0);
        check("mis_valid", mem_wb.valid, 1);

        // ---- 5b: timeout ----
        set_op(OPC_LOAD, 3'b010, 32'h400, 32'h0, 32'h0, 32'h0, 32'h44);
        #1;
        n = 0;
        while (!rdy && n < 400) begin
            step();
            n++;
        end
        check("to_cycles", n, 255);
        check("to_req_last", dmem_req, 1);
        step();
        set_op(OPC_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 32'h99, 32'h48);
        #1;
        check("to_req_dropped", dmem_req, 0);
        check("to_fault", mem_wb.fault, 1);
        check("to_valid", mem_wb.valid, 1);
        check("to_pc", mem_wb.pc, 32'h44);
        step();
        check("alu_after_to", mem_wb.wb_value, 32'h99);

        // ---- en dropped in WAIT ----
        set_op(OPC_LOAD, 3'b010, 32'h600, 32'h0, 32'h0, 32'h0, 32'h4C);
        step();
        en = 1'b0;
        step();
        bus(1'b1, 32'h11, 1'b0);
        #1;
        check("kill_rdy", rdy, 0);
        step();
        check("kill_valid", mem_wb.valid, 0);
        check("kill_pc", mem_wb.pc, 32'h4C);
        bus(1'b0, 32'h0, 1'b0);
        en = 1'b1;

        // ---- non-mem op held while writeback stalled ----
        set_op(OPC_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 32'h77, 32'h50);
        next_rdy = 1'b0;
        #1;
        check("alu_stall_rdy", rdy, 0);
        step();
        check("alu_stall_hold", mem_wb.pc, 32'h4C);
        next_rdy = 1'b1;
        step();
        check("alu_value", mem_wb.wb_value, 32'h77);
        check("alu_valid", mem_wb.valid, 1);

        // ---- 6: reset during WAIT ----
        set_op(OPC_LOAD, 3'b010, 32'h500, 32'h0, 32'h0, 32'h0, 32'h54);
        step();
        step();
        check("rstw_req_before", dmem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_op(OPC_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 32'h55, 32'h58);
        #1;
        check("rstw_req_after", dmem_req, 0);
        check("rstw_wb_pc", mem_wb.pc, 0);
        check("rstw_wb_valid", mem_wb.valid, 0);
        check("rstw_alu_rdy", rdy, 1);
        step();
        check("rstw_alu_value", mem_wb.wb_value, 32'h55);
        check("rstw_alu_valid", mem_wb.valid, 1);
        check("rstw_alu_fault", mem_wb.fault, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
